// File: rtl/ctrl_pkg.sv
// Shared control-path definitions: opcodes, field codes and the packed stage bundles.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LWU   = 6'b100111;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // RTYPE funct codes for register jumps
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  // ALUOp codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_BR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_RT  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_LUI = 3'b111;

  // Memory access size codes
  localparam logic [1:0] LONG_B = 2'b00;
  localparam logic [1:0] LONG_H = 2'b01;
  localparam logic [1:0] LONG_W = 2'b11;

  // Register destination select
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  // Writeback source select
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  // Bundle widths, MSB-first packing order as declared below
  localparam int EX_BITS  = 7;
  localparam int MEM_BITS = 6;
  localparam int WB_BITS  = 3;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       mem_read;
  } ex_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       mem_sign;
    logic       reg_write;
    logic [1:0] long_sz;
  } mem_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] mem_to_reg;
  } wb_t;

  // ID-stage controls consumed before the pipeline registers
  typedef struct packed {
    logic sgn;
    logic branch;
    logic branchne;
    logic jump;
    logic jump_reg;
  } id_t;

  typedef struct packed {
    id_t  id;
    ex_t  ex;
    mem_t mem;
    wb_t  wb;
  } bundle_t;

  // Access size of a load/store opcode; 0 for anything else.
  function automatic logic [1:0] size_code(input logic [5:0] op);
    logic [1:0] sz;
    sz = LONG_B;
    case (op)
      OP_LH, OP_LHU, OP_SH:        sz = LONG_H;
      OP_LW, OP_LWU, OP_SW:        sz = LONG_W;
      default:                     sz = LONG_B;
    endcase
    return sz;
  endfunction

  // Loads whose result is sign-extended.
  function automatic logic sign_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decoder producing the full ID/EX/MEM/WB control bundle.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; gating by valid/stall/flush is done by the caller.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6,
  parameter bit EN_JR   = 1'b1
) (
  input  logic [OP_W-1:0]    i_op,
  input  logic [FUNCT_W-1:0] i_funct,
  output bundle_t            o_bundle
);

  logic [5:0] op6;
  assign op6 = 6'(i_op);

  // Table decode; every field not named for an opcode stays 0, unknown opcodes give all zeros.
  always_comb begin
    o_bundle = '0;
    case (i_op)
      OP_W'(OP_RTYPE): begin
        o_bundle.ex.reg_dst   = DST_RD;
        o_bundle.ex.alu_op    = ALU_RT;
        o_bundle.wb.reg_write = 1'b1;
        if (EN_JR && (i_funct == FUNCT_W'(FN_JR))) begin
          o_bundle.id.jump_reg  = 1'b1;
          o_bundle.ex.reg_dst   = DST_RT;
          o_bundle.wb.reg_write = 1'b0;
        end else if (EN_JR && (i_funct == FUNCT_W'(FN_JALR))) begin
          o_bundle.id.jump_reg   = 1'b1;
          o_bundle.wb.mem_to_reg = WB_PC;
        end
      end
      OP_W'(OP_LB), OP_W'(OP_LH), OP_W'(OP_LW),
      OP_W'(OP_LWU), OP_W'(OP_LBU), OP_W'(OP_LHU): begin
        o_bundle.id.sgn        = 1'b1;
        o_bundle.ex.alu_op     = ALU_ADD;
        o_bundle.ex.alu_src    = 1'b1;
        o_bundle.mem.mem_read  = 1'b1;
        o_bundle.mem.mem_sign  = sign_load(op6);
        o_bundle.mem.long_sz   = size_code(op6);
        o_bundle.wb.reg_write  = 1'b1;
        o_bundle.wb.mem_to_reg = WB_MEM;
      end
      OP_W'(OP_SB), OP_W'(OP_SH), OP_W'(OP_SW): begin
        o_bundle.id.sgn        = 1'b1;
        o_bundle.ex.alu_op     = ALU_ADD;
        o_bundle.ex.alu_src    = 1'b1;
        o_bundle.mem.mem_write = 1'b1;
        o_bundle.mem.long_sz   = size_code(op6);
      end
      OP_W'(OP_ADDI): begin
        o_bundle.ex.alu_op    = ALU_ADD;
        o_bundle.ex.alu_src   = 1'b1;
        o_bundle.wb.reg_write = 1'b1;
      end
      OP_W'(OP_ANDI): begin
        o_bundle.ex.alu_op    = ALU_AND;
        o_bundle.ex.alu_src   = 1'b1;
        o_bundle.wb.reg_write = 1'b1;
      end
      OP_W'(OP_ORI): begin
        o_bundle.ex.alu_op    = ALU_OR;
        o_bundle.ex.alu_src   = 1'b1;
        o_bundle.wb.reg_write = 1'b1;
      end
      OP_W'(OP_XORI): begin
        o_bundle.ex.alu_op    = ALU_XOR;
        o_bundle.ex.alu_src   = 1'b1;
        o_bundle.wb.reg_write = 1'b1;
      end
      OP_W'(OP_LUI): begin
        o_bundle.ex.alu_op    = ALU_LUI;
        o_bundle.ex.alu_src   = 1'b1;
        o_bundle.wb.reg_write = 1'b1;
      end
      OP_W'(OP_SLTI): begin
        o_bundle.ex.alu_op    = ALU_SLT;
        o_bundle.ex.alu_src   = 1'b1;
        o_bundle.wb.reg_write = 1'b1;
      end
      OP_W'(OP_BEQ): begin
        o_bundle.id.sgn    = 1'b1;
        o_bundle.id.branch = 1'b1;
        o_bundle.ex.alu_op = ALU_BR;
      end
      OP_W'(OP_BNE): begin
        o_bundle.id.branchne = 1'b1;
        o_bundle.ex.alu_op   = ALU_BR;
      end
      OP_W'(OP_J): begin
        o_bundle.id.jump = 1'b1;
      end
      OP_W'(OP_JAL): begin
        o_bundle.id.jump       = 1'b1;
        o_bundle.ex.reg_dst    = DST_RA;
        o_bundle.wb.reg_write  = 1'b1;
        o_bundle.wb.mem_to_reg = WB_PC;
      end
      OP_W'(OP_HLT): begin
        o_bundle.ex.alu_op = ALU_RT;
      end
      default: o_bundle = '0;
    endcase
    // The EX copy of MemRead and the MEM copy of RegWrite mirror their home fields.
    o_bundle.ex.mem_read   = o_bundle.mem.mem_read;
    o_bundle.mem.reg_write = o_bundle.wb.reg_write;
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decodes in ID and carries EX/MEM/WB bundles through three stage registers.
// Latency: EX controls 1 enabled cycle after acceptance, MEM 2, WB 3; ID controls combinational.
// Backpressure: i_Stall/i_Flush bubble ID/EX only, later stages always advance; i_Enable=0 freezes all state.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 3,
  parameter bit EN_JR   = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_Enable,
  input  logic               i_Valid,
  input  logic [OP_W-1:0]    i_Op,
  input  logic [FUNCT_W-1:0] i_Funct,
  input  logic               i_Stall,
  input  logic               i_Flush,
  output logic               o_Signed,
  output logic               o_Branch,
  output logic               o_Branchne,
  output logic               o_Jump,
  output logic               o_JumpReg,
  output logic               o_HaltFetch,
  output logic [1:0]         o_ex_RegDst,
  output logic [ALUOP_W-1:0] o_ex_ALUOp,
  output logic               o_ex_ALUSrc,
  output logic               o_ex_MemRead,
  output logic               o_ex_RegWrite,
  output logic               o_mem_MemRead,
  output logic               o_mem_MemWrite,
  output logic               o_mem_MemSign,
  output logic               o_mem_RegWrite,
  output logic [1:0]         o_mem_Long,
  output logic               o_wb_RegWrite,
  output logic [1:0]         o_wb_MemtoReg,
  output logic               o_Halted
);

  bundle_t dec;
  logic    is_hlt;
  logic    effective;
  logic    accept;
  logic    halt_pending;
  logic    halted;

  logic    idex_vld;
  logic    idex_halt;
  ex_t     idex_ex;
  mem_t    idex_mem;
  wb_t     idex_wb;

  logic    exmem_vld;
  logic    exmem_halt;
  mem_t    exmem_mem;
  wb_t     exmem_wb;

  logic    memwb_vld;
  logic    memwb_halt;
  wb_t     memwb_wb;

  ex_t     ex_q;
  mem_t    mem_q;
  wb_t     wb_q;

  ctrl_decode #(
    .OP_W    (OP_W),
    .FUNCT_W (FUNCT_W),
    .EN_JR   (EN_JR)
  ) u_decode (
    .i_op     (i_Op),
    .i_funct  (i_Funct),
    .o_bundle (dec)
  );

  // An instruction counts only if valid, not killed by a taken branch, and no halt is draining.
  assign is_hlt    = (i_Op == OP_W'(OP_HLT));
  assign effective = i_Valid & ~i_Flush & ~halt_pending;
  assign accept    = effective & ~i_Stall;

  assign o_Signed    = effective & dec.id.sgn;
  assign o_Branch    = effective & dec.id.branch;
  assign o_Branchne  = effective & dec.id.branchne;
  assign o_Jump      = effective & dec.id.jump;
  assign o_JumpReg   = effective & dec.id.jump_reg;
  // A stalled HLT already stops fetch even though it has not been accepted yet.
  assign o_HaltFetch = halt_pending | (effective & is_hlt);

  // ID/EX: capture the decoded bundle on acceptance, otherwise insert a bubble.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idex_vld  <= 1'b0;
      idex_halt <= 1'b0;
      idex_ex   <= '0;
      idex_mem  <= '0;
      idex_wb   <= '0;
    end else if (i_Enable) begin
      if (accept) begin
        idex_vld  <= 1'b1;
        idex_halt <= is_hlt;
        idex_ex   <= dec.ex;
        idex_mem  <= dec.mem;
        idex_wb   <= dec.wb;
      end else begin
        idex_vld  <= 1'b0;
        idex_halt <= 1'b0;
        idex_ex   <= '0;
        idex_mem  <= '0;
        idex_wb   <= '0;
      end
    end
  end

  // EX/MEM: always advances; a stall in ID does not hold instructions already past it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      exmem_vld  <= 1'b0;
      exmem_halt <= 1'b0;
      exmem_mem  <= '0;
      exmem_wb   <= '0;
    end else if (i_Enable) begin
      exmem_vld  <= idex_vld;
      exmem_halt <= idex_halt;
      exmem_mem  <= idex_mem;
      exmem_wb   <= idex_wb;
    end
  end

  // MEM/WB: always advances.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      memwb_vld  <= 1'b0;
      memwb_halt <= 1'b0;
      memwb_wb   <= '0;
    end else if (i_Enable) begin
      memwb_vld  <= exmem_vld;
      memwb_halt <= exmem_halt;
      memwb_wb   <= exmem_wb;
    end
  end

  // Halt sequence: accepted HLT blocks ID; once it leaves WB the unit reports halted until reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      halt_pending <= 1'b0;
      halted       <= 1'b0;
    end else if (i_Enable) begin
      if (accept && is_hlt) begin
        halt_pending <= 1'b1;
      end
      if (memwb_halt) begin
        halted <= 1'b1;
      end
    end
  end

  // Stage outputs are forced to zero for bubbles.
  assign ex_q  = idex_vld  ? idex_ex   : ex_t'('0);
  assign mem_q = exmem_vld ? exmem_mem : mem_t'('0);
  assign wb_q  = memwb_vld ? memwb_wb  : wb_t'('0);

  assign o_ex_RegDst    = ex_q.reg_dst;
  assign o_ex_ALUOp     = ALUOP_W'(ex_q.alu_op);
  assign o_ex_ALUSrc    = ex_q.alu_src;
  assign o_ex_MemRead   = ex_q.mem_read;
  assign o_ex_RegWrite  = idex_vld & idex_wb.reg_write;

  assign o_mem_MemRead  = mem_q.mem_read;
  assign o_mem_MemWrite = mem_q.mem_write;
  assign o_mem_MemSign  = mem_q.mem_sign;
  assign o_mem_RegWrite = mem_q.reg_write;
  assign o_mem_Long     = mem_q.long_sz;

  assign o_wb_RegWrite  = wb_q.reg_write;
  assign o_wb_MemtoReg  = wb_q.mem_to_reg;

  assign o_Halted       = halted;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
module tb_ctrl_pipe_unit;

  localparam logic [5:0] RTYPE = 6'b000000, LB = 6'b100000, LH = 6'b100001, LW = 6'b100011;
  localparam logic [5:0] LWU = 6'b100111, LBU = 6'b100100, LHU = 6'b100101;
  localparam logic [5:0] SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;
  localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101, XORI = 6'b001110;
  localparam logic [5:0] LUI = 6'b001111, SLTI = 6'b001010, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] J = 6'b000010, JAL = 6'b000011, HLT = 6'b111111, BAD = 6'b010111;

  // Control record of one instruction, as the reference model understands it.
  typedef struct packed {
    logic sgn, br, brne, jmp, jreg;
    logic [1:0] dst;
    logic [2:0] alu;
    logic src, mrd, mwr, msg, rw;
    logic [1:0] lng, m2r;
  } ctl_t;

  // One in-flight pipeline slot: was something accepted, and what was it.
  typedef struct packed {
    logic acc;
    logic [5:0] op;
    logic [5:0] fn;
  } slot_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, vld, st, fl;
  logic [5:0] op, fn;

  logic sgn_a, br_a, brne_a, jmp_a, jreg_a, hf_a, exsrc_a, exrd_a, exrw_a;
  logic mrd_a, mwr_a, msg_a, mrw_a, wrw_a, hlt_a;
  logic [1:0] dst_a, lng_a, m2r_a;
  logic [2:0] alu_a;
  logic sgn_b, br_b, brne_b, jmp_b, jreg_b, hf_b, exsrc_b, exrd_b, exrw_b;
  logic mrd_b, mwr_b, msg_b, mrw_b, wrw_b, hlt_b;
  logic [1:0] dst_b, lng_b, m2r_b;
  logic [2:0] alu_b;

  ctrl_pipe_unit #(.OP_W(6), .FUNCT_W(6), .ALUOP_W(3), .EN_JR(1'b1)) dut_jr (
    .i_clk(clk), .i_reset(rst), .i_Enable(en), .i_Valid(vld), .i_Op(op), .i_Funct(fn),
    .i_Stall(st), .i_Flush(fl),
    .o_Signed(sgn_a), .o_Branch(br_a), .o_Branchne(brne_a), .o_Jump(jmp_a), .o_JumpReg(jreg_a),
    .o_HaltFetch(hf_a), .o_ex_RegDst(dst_a), .o_ex_ALUOp(alu_a), .o_ex_ALUSrc(exsrc_a),
    .o_ex_MemRead(exrd_a), .o_ex_RegWrite(exrw_a), .o_mem_MemRead(mrd_a), .o_mem_MemWrite(mwr_a),
    .o_mem_MemSign(msg_a), .o_mem_RegWrite(mrw_a), .o_mem_Long(lng_a), .o_wb_RegWrite(wrw_a),
    .o_wb_MemtoReg(m2r_a), .o_Halted(hlt_a)
  );

  ctrl_pipe_unit #(.OP_W(6), .FUNCT_W(6), .ALUOP_W(3), .EN_JR(1'b0)) dut_nojr (
    .i_clk(clk), .i_reset(rst), .i_Enable(en), .i_Valid(vld), .i_Op(op), .i_Funct(fn),
    .i_Stall(st), .i_Flush(fl),
    .o_Signed(sgn_b), .o_Branch(br_b), .o_Branchne(brne_b), .o_Jump(jmp_b), .o_JumpReg(jreg_b),
    .o_HaltFetch(hf_b), .o_ex_RegDst(dst_b), .o_ex_ALUOp(alu_b), .o_ex_ALUSrc(exsrc_b),
    .o_ex_MemRead(exrd_b), .o_ex_RegWrite(exrw_b), .o_mem_MemRead(mrd_b), .o_mem_MemWrite(mwr_b),
    .o_mem_MemSign(msg_b), .o_mem_RegWrite(mrw_b), .o_mem_Long(lng_b), .o_wb_RegWrite(wrw_b),
    .o_wb_MemtoReg(m2r_b), .o_Halted(hlt_b)
  );

  int checks = 0;
  int failures = 0;

  logic  m_hp, m_halted;
  slot_t hist [3];

  // Reference decode: instruction classes, with load/store size taken from opcode bits 1:0.
  function automatic ctl_t dec(input logic [5:0] o, input logic [5:0] f, input logic jr);
    ctl_t c;
    c = '0;
    case (o)
      RTYPE: begin
        c.dst = 2'b01; c.alu = 3'b011; c.rw = 1'b1;
        if (jr && f == 6'b001000) begin c.jreg = 1'b1; c.rw = 1'b0; c.dst = 2'b00; end
        else if (jr && f == 6'b001001) begin c.jreg = 1'b1; c.m2r = 2'b10; end
      end
      LB, LH, LW, LWU, LBU, LHU: begin
        c.sgn = 1'b1; c.src = 1'b1; c.mrd = 1'b1; c.rw = 1'b1; c.m2r = 2'b01;
        c.lng = o[1:0]; c.msg = ~o[2];
      end
      SB, SH, SW: begin c.sgn = 1'b1; c.src = 1'b1; c.mwr = 1'b1; c.lng = o[1:0]; end
      ADDI: begin c.alu = 3'b000; c.src = 1'b1; c.rw = 1'b1; end
      ANDI: begin c.alu = 3'b100; c.src = 1'b1; c.rw = 1'b1; end
      ORI:  begin c.alu = 3'b101; c.src = 1'b1; c.rw = 1'b1; end
      XORI: begin c.alu = 3'b110; c.src = 1'b1; c.rw = 1'b1; end
      LUI:  begin c.alu = 3'b111; c.src = 1'b1; c.rw = 1'b1; end
      SLTI: begin c.alu = 3'b010; c.src = 1'b1; c.rw = 1'b1; end
      BEQ:  begin c.alu = 3'b001; c.br = 1'b1; c.sgn = 1'b1; end
      BNE:  begin c.alu = 3'b001; c.brne = 1'b1; end
      J:    c.jmp = 1'b1;
      JAL:  begin c.jmp = 1'b1; c.dst = 2'b10; c.rw = 1'b1; c.m2r = 2'b10; end
      HLT:  c.alu = 3'b011;
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output of both instances against the model's view of the current cycle.
  task automatic check_all();
    logic e;
    ctl_t c, x, m, w;
    logic [5:0] eid, oid, emem, omem;
    logic [7:0] eex, oex;
    logic [2:0] ewb, owb;
    logic oh;
    e = vld && !fl && !m_hp;
    for (int k = 0; k < 2; k++) begin
      c = dec(op, fn, k == 0);
      x = hist[0].acc ? dec(hist[0].op, hist[0].fn, k == 0) : '0;
      m = hist[1].acc ? dec(hist[1].op, hist[1].fn, k == 0) : '0;
      w = hist[2].acc ? dec(hist[2].op, hist[2].fn, k == 0) : '0;
      eid = e ? {c.sgn, c.br, c.brne, c.jmp, c.jreg, 1'b0} : 6'b0;
      eid[0] = m_hp || (e && op == HLT);
      eex  = {x.dst, x.alu, x.src, x.mrd, x.rw};
      emem = {m.mrd, m.mwr, m.msg, m.rw, m.lng};
      ewb  = {w.rw, w.m2r};
      if (k == 0) begin
        oid = {sgn_a, br_a, brne_a, jmp_a, jreg_a, hf_a};
        oex = {dst_a, alu_a, exsrc_a, exrd_a, exrw_a};
        omem = {mrd_a, mwr_a, msg_a, mrw_a, lng_a};
        owb = {wrw_a, m2r_a};
        oh = hlt_a;
      end else begin
        oid = {sgn_b, br_b, brne_b, jmp_b, jreg_b, hf_b};
        oex = {dst_b, alu_b, exsrc_b, exrd_b, exrw_b};
        omem = {mrd_b, mwr_b, msg_b, mrw_b, lng_b};
        owb = {wrw_b, m2r_b};
        oh = hlt_b;
      end
      chk($sformatf("id_k%0d", k), 32'(oid), 32'(eid));
      chk($sformatf("ex_k%0d", k), 32'(oex), 32'(eex));
      chk($sformatf("mem_k%0d", k), 32'(omem), 32'(emem));
      chk($sformatf("wb_k%0d", k), 32'(owb), 32'(ewb));
      chk($sformatf("halted_k%0d", k), 32'(oh), 32'(m_halted));
    end
  endtask

  // Model clock edge: shift the slot history and track the halt flags.
  task automatic model_update();
    logic e;
    if (rst) begin
      m_hp = 1'b0; m_halted = 1'b0;
      for (int i = 0; i < 3; i++) hist[i] = '0;
    end else if (en) begin
      e = vld && !fl && !m_hp;
      if (hist[2].acc && hist[2].op == HLT) m_halted = 1'b1;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0].acc = e && !st;
      hist[0].op = op;
      hist[0].fn = fn;
      if (e && !st && op == HLT) m_hp = 1'b1;
    end
  endtask

  // Drive one cycle's inputs, check before the edge, then advance the model past the edge.
  task automatic step(input logic a_v, input logic [5:0] a_op, input logic [5:0] a_fn,
                      input logic a_st, input logic a_fl, input logic a_en, input logic a_rst);
    @(negedge clk);
    vld = a_v; op = a_op; fn = a_fn; st = a_st; fl = a_fl; en = a_en; rst = a_rst;
    #1 check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    step(1'b0, 6'b0, 6'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  logic [5:0] ops [22] = '{RTYPE, LB, LH, LW, LWU, LBU, LHU, SB, SH, SW, ADDI, ANDI, ORI,
                           XORI, LUI, SLTI, BEQ, BNE, J, JAL, HLT, BAD};

  initial begin
    logic [5:0] ro, rf;
    int r;
    rst = 1'b1; en = 1'b0; vld = 1'b0; st = 1'b0; fl = 1'b0; op = '0; fn = '0;
    repeat (2) @(posedge clk);
    model_update();
    #1;

    // LW through all three stages
    step(1'b1, LW, 6'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("lw_ex", 32'({alu_a, exsrc_a, exrd_a}), 32'(5'b00011));
    idle();
    chk("lw_mem", 32'({lng_a, msg_a}), 32'(3'b111));
    idle();
    chk("lw_wb", 32'({m2r_a, wrw_a}), 32'(3'b011));

    // ADDI, then LBU stalled one cycle
    step(1'b1, ADDI, 6'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("addi_ex", 32'({alu_a, exsrc_a, exrw_a}), 32'(5'b00011));
    step(1'b1, LBU, 6'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("stall_bubble", 32'({dst_a, alu_a, exsrc_a, exrd_a, exrw_a}), 32'(0));
    step(1'b1, LBU, 6'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("lbu_ex", 32'({alu_a, exsrc_a, exrd_a}), 32'(5'b00011));
    idle();
    chk("lbu_mem", 32'({mrd_a, msg_a, lng_a}), 32'(4'b1000));

    // Flush and stall together on a BEQ
    step(1'b1, BEQ, 6'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush_branch", 32'(br_a), 32'(0));
    chk("flush_ex", 32'({dst_a, alu_a, exsrc_a, exrd_a, exrw_a}), 32'(0));

    // Halt and drain
    step(1'b0, 6'b0, 6'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, HLT, 6'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("hlt_fetch", 32'(hf_a), 32'(1));
    step(1'b1, RTYPE, 6'b100000, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("hlt_add_bubble", 32'({dst_a, alu_a, exsrc_a, exrd_a, exrw_a}), 32'(0));
    chk("hlt_fetch_held", 32'(hf_a), 32'(1));
    idle();
    chk("halted_c3", 32'(hlt_a), 32'(0));
    idle();
    chk("halted_c4", 32'(hlt_a), 32'(1));
    idle(); idle();
    chk("halted_sticky", 32'(hlt_a), 32'(1));
    step(1'b0, 6'b0, 6'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("halted_reset", 32'(hlt_a), 32'(0));

    // JALR with and without register-jump decode
    step(1'b1, RTYPE, 6'b001001, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("jalr_jr_on", 32'(jreg_a), 32'(1));
    chk("jalr_jr_off", 32'(jreg_b), 32'(0));
    idle(); idle();
    chk("jalr_wb_on", 32'({wrw_a, m2r_a}), 32'(3'b110));
    chk("jalr_wb_off", 32'({wrw_b, m2r_b}), 32'(3'b100));

    // Freeze with enable low, then resume
    step(1'b1, ORI, 6'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, SW, 6'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, XORI, 6'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, ANDI, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, LUI, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, BNE, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("freeze_ex", 32'(alu_a), 32'(3'b110));
    chk("freeze_mem", 32'({mwr_a, lng_a}), 32'(3'b111));
    step(1'b1, ANDI, 6'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("resume_ex", 32'(alu_a), 32'(3'b100));
    chk("resume_mem", 32'(mwr_a), 32'(0));

    // Unknown opcode
    step(1'b1, BAD, 6'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bad_id", 32'({sgn_a, br_a, brne_a, jmp_a, jreg_a}), 32'(0));
    chk("bad_ex", 32'({dst_a, alu_a, exsrc_a, exrd_a, exrw_a}), 32'(0));

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      ro = ops[$urandom_range(0, 21)];
      r = $urandom_range(0, 3);
      rf = (r == 0) ? 6'b001000 : (r == 1) ? 6'b001001 : 6'($urandom);
      step($urandom_range(0, 9) != 0, ro, rf, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 29) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
